// File: rtl/adder.sv
// Unsigned adder, {cout, sum} = a + b + cin. Each GROUP-bit group resolves its carries
// by lookahead from its own carry-in; group carries ripple. Output register is optional.
module adder #(
  parameter int WIDTH   = 4,
  parameter int GROUP   = 4,
  parameter int OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NGROUPS = (WIDTH + GROUP - 1) / GROUP;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  assign g = a & b;
  assign p = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < NGROUPS; gi++) begin : g_grp
      localparam int LO = gi * GROUP;
      localparam int SZ = ((WIDTH - LO) < GROUP) ? (WIDTH - LO) : GROUP;

      logic          cin_grp;
      logic          carry_out;
      logic [SZ-1:0] s;

      if (gi == 0) begin : g_first
        assign cin_grp = cin;
      end else begin : g_chain
        assign cin_grp = g_grp[gi-1].carry_out;
      end

      // Carry into bit k+1 is the group-generate of bits 0..k, or their
      // group-propagate AND the group carry-in; no dependence on bit k's carry.
      always_comb begin
        logic gen_acc;
        logic prop_acc;
        logic c_k;
        s         = '0;
        carry_out = 1'b0;
        c_k       = cin_grp;
        for (int k = 0; k < SZ; k++) begin
          s[k]     = p[LO+k] ^ c_k;
          gen_acc  = 1'b0;
          prop_acc = 1'b1;
          for (int j = 0; j <= k; j++) begin
            gen_acc  = g[LO+j] | (p[LO+j] & gen_acc);
            prop_acc = prop_acc & p[LO+j];
          end
          c_k = gen_acc | (prop_acc & cin_grp);
        end
        carry_out = c_k;
      end

      assign sum_d[LO+SZ-1:LO] = s;
    end
  endgenerate

  assign cout_d = g_grp[NGROUPS-1].carry_out;

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [WIDTH-1:0] sum_q;
      logic             cout_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
        end else begin
          sum_q  <= sum_d;
          cout_q <= cout_d;
        end
      end

      assign sum  = sum_q;
      assign cout = cout_q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign sum  = sum_d;
      assign cout = cout_d;
    end
  endgenerate

endmodule

// File: tb/tb_adder.sv
// Directed and swept checks of adder in three configurations: combinational 4-bit,
// registered 8-bit, and 13-bit with a partial last lookahead group.
module tb_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Default combinational 4-bit instance
  logic [3:0] a4, b4, sum4;
  logic       cin4, cout4;
  adder u_add4 (.clk(clk), .rst(1'b0), .a(a4), .b(b4), .cin(cin4), .sum(sum4), .cout(cout4));

  // Registered 8-bit instance
  logic       rst8;
  logic [7:0] a8, b8, sum8;
  logic       cin8, cout8;
  adder #(.WIDTH(8), .GROUP(4), .OUT_REG(1)) u_add8 (
    .clk(clk), .rst(rst8), .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8));

  // 13-bit combinational instance, last group is one bit wide
  logic [12:0] a13, b13, sum13;
  logic        cin13, cout13;
  adder #(.WIDTH(13), .GROUP(4), .OUT_REG(0)) u_add13 (
    .clk(clk), .rst(1'b0), .a(a13), .b(b13), .cin(cin13), .sum(sum13), .cout(cout13));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
  } vec4_t;

  vec4_t dir4 [6] = '{
    '{4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0},
    '{4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b0},
    '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1},
    '{4'b1010, 4'b0110, 1'b0, 4'b0000, 1'b1},
    '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0},
    '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1}
  };

  task automatic check8(input string tag, input logic [7:0] es, input logic ec);
    $display("reg8 %s: a=%0d b=%0d cin=%0d rst=%0d -> sum=%0d cout=%0d", tag, a8, b8, cin8, rst8, sum8, cout8);
    check({tag, ".sum"}, 64'(sum8), 64'(es));
    check({tag, ".cout"}, 64'(cout8), 64'(ec));
  endtask

  initial begin
    logic [4:0]  exp5;
    logic [13:0] exp14;

    rst8 = 1'b1;
    a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    a13 = '0; b13 = '0; cin13 = 1'b0;

    // Directed 4-bit vectors
    for (int i = 0; i < 6; i++) begin
      a4 = dir4[i].a; b4 = dir4[i].b; cin4 = dir4[i].cin;
      #1;
      $display("add4 dir%0d: a=%b b=%b cin=%b -> sum=%b cout=%b", i, a4, b4, cin4, sum4, cout4);
      check($sformatf("dir%0d.sum", i), 64'(sum4), 64'(dir4[i].sum));
      check($sformatf("dir%0d.cout", i), 64'(cout4), 64'(dir4[i].cout));
    end

    // Exhaustive 4-bit sweep
    for (int i = 0; i < 512; i++) begin
      a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8];
      #1;
      exp5 = 5'(a4) + 5'(b4) + 5'(cin4);
      check($sformatf("sweep a=%0d b=%0d c=%0d", a4, b4, cin4), 64'({cout4, sum4}), 64'(exp5));
    end
    $display("add4 exhaustive sweep: 512 vectors");

    // 13-bit edge cases then random vectors
    a13 = '0; b13 = '0; cin13 = 1'b0; #1;
    check("w13.zero", 64'({cout13, sum13}), 64'd0);
    a13 = 13'h1fff; b13 = 13'd1; cin13 = 1'b0; #1;
    check("w13.ones_plus1", 64'({cout13, sum13}), 64'h2000);
    a13 = 13'h1fff; b13 = 13'h1fff; cin13 = 1'b1; #1;
    check("w13.max", 64'({cout13, sum13}), 64'h3fff);
    a13 = 13'h0fff; b13 = 13'd0; cin13 = 1'b1; #1;
    check("w13.carry_into_last_group", 64'({cout13, sum13}), 64'h1000);
    for (int i = 0; i < 10000; i++) begin
      a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
      #1;
      exp14 = 14'(a13) + 14'(b13) + 14'(cin13);
      check($sformatf("w13.rand%0d", i), 64'({cout13, sum13}), 64'(exp14));
    end
    $display("add13 random sweep: 10000 vectors");

    // Registered 8-bit: reset hold, latency, async clear, restart
    repeat (2) @(posedge clk);
    #1 check8("reset_hold", 8'd0, 1'b0);
    @(negedge clk);
    rst8 = 1'b0; a8 = 8'd200; b8 = 8'd100; cin8 = 1'b0;
    #1 check8("pre_edge", 8'd0, 1'b0);
    @(posedge clk);
    #1 check8("first_update", 8'd44, 1'b1);
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd20; cin8 = 1'b1;
    @(posedge clk);
    #1 check8("second_update", 8'd31, 1'b0);
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd255; cin8 = 1'b1;
    #2 rst8 = 1'b1;
    #1 check8("async_clear", 8'd0, 1'b0);
    @(posedge clk);
    #1 check8("held_in_reset", 8'd0, 1'b0);
    @(negedge clk);
    rst8 = 1'b0;
    #1 check8("released_pre_edge", 8'd0, 1'b0);
    @(posedge clk);
    #1 check8("restart_update", 8'd255, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
